// File: rtl/router_pkg.sv
// Shared types and helpers for the router packet generator: FSM state encoding,
// header/address constants and the payload LFSR step function.
package router_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_PAY  = 3'd2,
        ST_PAR  = 3'd3,
        ST_WAIT = 3'd4,
        ST_GAP  = 3'd5
    } state_e;

    localparam int         BYTE_W       = 8;
    localparam int         ADDR_W       = 2;
    localparam logic [1:0] ADDR_ILLEGAL = 2'b11;
    localparam logic [7:0] SEED_SUB     = 8'h01;

    // Fibonacci step, taps 7/5/4/3, shifting towards the MSB.
    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

endpackage

// File: rtl/router_lfsr8.sv
// 8-bit payload LFSR: load (with zero-seed substitution), advance or hold.
module router_lfsr8
    import router_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [7:0]  seed_i,
    input  logic        adv_i,
    output logic [7:0]  lfsr_o,
    output logic [7:0]  lfsr_nxt_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // An all-zero state would lock the LFSR, so a zero seed becomes SEED_SUB.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (seed_i == 8'h00) ? SEED_SUB : seed_i;
        end else if (adv_i) begin
            lfsr_d = lfsr_next(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED_SUB;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o     = lfsr_q;
    assign lfsr_nxt_o = lfsr_next(lfsr_q);

endmodule

// File: rtl/router_pkt_gen.sv
// Packet source for the router input port: header, LFSR payload, parity, error window.
// Optional build macro ROUTER_PKT_GEN_CORRUPT_EN adds corrupt_par (inverted parity byte).
module router_pkt_gen #(
    parameter int LEN_W    = 6,
    parameter int ERR_WAIT = 3,
    parameter int GAP      = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [7:0]       cmd_seed,
`ifdef ROUTER_PKT_GEN_CORRUPT_EN
    input  logic             corrupt_par,
`endif
    output logic [7:0]       d_in,
    output logic             pkt_vld,
    input  logic             busy,
    input  logic             error,
    output logic             pkt_done,
    output logic             pkt_err,
    output logic             cmd_err,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    import router_pkg::*;

    localparam int WAIT_W    = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;
    localparam int GAP_W     = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GAP_LOAD  = (GAP > 0) ? GAP - 1 : 0;
    localparam int WAIT_LOAD = ERR_WAIT - 1;

    state_e             state_q, state_d;
    logic [7:0]         d_in_q, d_in_d;
    logic               pkt_vld_q, pkt_vld_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               pkt_done_q, pkt_done_d;
    logic               pkt_err_q, pkt_err_d;
    logic               cmd_err_q, cmd_err_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         par_q, par_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               err_or_q, err_or_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               corrupt_q, corrupt_d;

    logic               corrupt_in_s;
    logic               acc_s;
    logic               fire_s;
    logic               legal_s;
    logic               err_any_s;
    logic               lfsr_load_s;
    logic               lfsr_adv_s;
    logic [7:0]         lfsr_s;
    logic [7:0]         lfsr_nxt_s;
    logic [7:0]         header_s;

`ifdef ROUTER_PKT_GEN_CORRUPT_EN
    assign corrupt_in_s = corrupt_par;
`else
    assign corrupt_in_s = 1'b0;
`endif

    assign acc_s     = !busy && (state_q == ST_HDR || state_q == ST_PAY || state_q == ST_PAR);
    assign fire_s    = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
    assign legal_s   = (cmd_len != '0) && (cmd_addr != ADDR_ILLEGAL);
    assign err_any_s = err_or_q | error;
    assign header_s  = BYTE_W'({cmd_len, cmd_addr});

    router_lfsr8 u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (lfsr_load_s),
        .seed_i     (cmd_seed),
        .adv_i      (lfsr_adv_s),
        .lfsr_o     (lfsr_s),
        .lfsr_nxt_o (lfsr_nxt_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = (fire_s && legal_s) ? ST_HDR : ST_IDLE;
            ST_HDR:  state_d = acc_s ? ST_PAY : ST_HDR;
            ST_PAY:  state_d = (acc_s && cnt_q == LEN_W'(1)) ? ST_PAR : ST_PAY;
            ST_PAR:  state_d = acc_s ? ST_WAIT : ST_PAR;
            ST_WAIT: begin
                if (wait_q == '0) begin
                    state_d = (GAP == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_GAP:  state_d = (gap_q == '0) ? ST_IDLE : ST_GAP;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; every byte is XORed into par when first driven.
    always_comb begin
        d_in_d      = d_in_q;
        pkt_vld_d   = pkt_vld_q;
        cmd_ready_d = (state_d == ST_IDLE);
        pkt_done_d  = 1'b0;
        pkt_err_d   = pkt_err_q;
        cmd_err_d   = 1'b0;
        pkt_cnt_d   = pkt_cnt_q;
        err_cnt_d   = err_cnt_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        par_d       = par_q;
        wait_d      = wait_q;
        err_or_d    = err_or_q;
        gap_d       = gap_q;
        corrupt_d   = corrupt_q;
        lfsr_load_s = 1'b0;
        lfsr_adv_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fire_s && legal_s) begin
                    len_d       = cmd_len;
                    d_in_d      = header_s;
                    pkt_vld_d   = 1'b1;
                    par_d       = header_s;
                    corrupt_d   = corrupt_in_s;
                    lfsr_load_s = 1'b1;
                end else if (fire_s) begin
                    cmd_err_d = 1'b1;
                end else begin
                    cmd_err_d = 1'b0;
                end
            end
            ST_HDR: begin
                if (acc_s) begin
                    d_in_d = lfsr_s;
                    par_d  = par_q ^ lfsr_s;
                    cnt_d  = len_q;
                end else begin
                    d_in_d = d_in_q;
                end
            end
            ST_PAY: begin
                if (acc_s && cnt_q == LEN_W'(1)) begin
                    d_in_d    = corrupt_q ? ~par_q : par_q;
                    pkt_vld_d = 1'b0;
                end else if (acc_s) begin
                    d_in_d     = lfsr_nxt_s;
                    par_d      = par_q ^ lfsr_nxt_s;
                    cnt_d      = cnt_q - LEN_W'(1);
                    lfsr_adv_s = 1'b1;
                end else begin
                    d_in_d = d_in_q;
                end
            end
            ST_PAR: begin
                if (acc_s) begin
                    d_in_d   = 8'h00;
                    wait_d   = WAIT_W'(WAIT_LOAD);
                    err_or_d = 1'b0;
                end else begin
                    d_in_d = d_in_q;
                end
            end
            ST_WAIT: begin
                // busy is deliberately ignored here; only the error window matters.
                if (wait_q == '0) begin
                    pkt_done_d = 1'b1;
                    pkt_err_d  = err_any_s;
                    pkt_cnt_d  = (pkt_cnt_q == '1) ? pkt_cnt_q : pkt_cnt_q + CNT_W'(1);
                    if (err_any_s && err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                    gap_d = GAP_W'(GAP_LOAD);
                end else begin
                    wait_d   = wait_q - WAIT_W'(1);
                    err_or_d = err_any_s;
                end
            end
            ST_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else begin
                    gap_d = gap_q;
                end
            end
            default: begin
                d_in_d    = 8'h00;
                pkt_vld_d = 1'b0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_in_q      <= 8'h00;
            pkt_vld_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            pkt_done_q  <= 1'b0;
            pkt_err_q   <= 1'b0;
            cmd_err_q   <= 1'b0;
            pkt_cnt_q   <= '0;
            err_cnt_q   <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            par_q       <= 8'h00;
            wait_q      <= '0;
            err_or_q    <= 1'b0;
            gap_q       <= '0;
            corrupt_q   <= 1'b0;
        end else begin
            d_in_q      <= d_in_d;
            pkt_vld_q   <= pkt_vld_d;
            cmd_ready_q <= cmd_ready_d;
            pkt_done_q  <= pkt_done_d;
            pkt_err_q   <= pkt_err_d;
            cmd_err_q   <= cmd_err_d;
            pkt_cnt_q   <= pkt_cnt_d;
            err_cnt_q   <= err_cnt_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            par_q       <= par_d;
            wait_q      <= wait_d;
            err_or_q    <= err_or_d;
            gap_q       <= gap_d;
            corrupt_q   <= corrupt_d;
        end
    end

    assign d_in      = d_in_q;
    assign pkt_vld   = pkt_vld_q;
    assign cmd_ready = cmd_ready_q;
    assign pkt_done  = pkt_done_q;
    assign pkt_err   = pkt_err_q;
    assign cmd_err   = cmd_err_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_router_pkt_gen.sv
// Self-checking bench for router_pkt_gen: directed spec cases plus randomized packets
// against a byte-list reference model; narrow counters exercise saturation.
module tb_router_pkt_gen;

    localparam int LEN_W    = 6;
    localparam int ERR_WAIT = 3;
    localparam int GAP      = 1;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_addr = 2'd0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [7:0]       cmd_seed = 8'h00;
    logic [7:0]       d_in;
    logic             pkt_vld;
    logic             busy = 1'b0;
    logic             error = 1'b0;
    logic             pkt_done;
    logic             pkt_err;
    logic             cmd_err;
    logic [CNT_W-1:0] pkt_cnt;
    logic [CNT_W-1:0] err_cnt;
`ifdef ROUTER_PKT_GEN_CORRUPT_EN
    logic             corrupt_par = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;
    int pkt_m = 0;
    int err_m = 0;
    logic [7:0] exp_q[$];

    router_pkt_gen #(.LEN_W(LEN_W), .ERR_WAIT(ERR_WAIT), .GAP(GAP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
`ifdef ROUTER_PKT_GEN_CORRUPT_EN
        .corrupt_par(corrupt_par),
`endif
        .d_in(d_in), .pkt_vld(pkt_vld), .busy(busy), .error(error),
        .pkt_done(pkt_done), .pkt_err(pkt_err), .cmd_err(cmd_err),
        .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference packet: header = len*4+addr, payload from the LFSR rule, XOR parity.
    task automatic build_exp(input logic [1:0] a, input int len, input logic [7:0] seed,
                             input logic corrupt);
        logic [7:0] s, p, h;
        exp_q.delete();
        h = 8'(len * 4 + int'(a));
        exp_q.push_back(h);
        p = h;
        s = (seed == 8'h00) ? 8'h01 : seed;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(s);
            p = p ^ s;
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end
        exp_q.push_back(corrupt ? ~p : p);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (cmd_ready !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_ready: cmd_ready=%b after %0d cycles, required 1", cmd_ready, t);
        end
    endtask

    // Sends one legal command and checks every accepted byte, the error window and counters.
    task automatic run_packet(input logic [1:0] a, input logic [5:0] len, input logic [7:0] seed,
                              input logic corrupt, input bit rnd_busy, input int stall_idx,
                              input int stall_n, input logic [7:0] err_mask, input bit pay_err);
        int idx = 0, stalls = 0, cyc = 0, n;
        logic errs = 1'b0;
        logic exp_vld;
        wait_ready();
        cmd_addr = a; cmd_len = len; cmd_seed = seed; cmd_valid = 1'b1;
`ifdef ROUTER_PKT_GEN_CORRUPT_EN
        corrupt_par = corrupt;
`endif
        step();
        cmd_valid = 1'b0;
`ifdef ROUTER_PKT_GEN_CORRUPT_EN
        corrupt_par = 1'b0;
`endif
        n = exp_q.size();
        while (idx < n && cyc < 400) begin
            exp_vld = (idx < n - 1);
            vectors++;
            if (d_in !== exp_q[idx] || pkt_vld !== exp_vld) begin
                miscompares++;
                $display("FAIL byte[%0d]: d_in=%h pkt_vld=%b, required %h/%b", idx, d_in, pkt_vld,
                         exp_q[idx], exp_vld);
            end
            if (idx == stall_idx && stalls < stall_n) begin
                busy = 1'b1;
                stalls++;
            end else if (rnd_busy) begin
                busy = ($urandom_range(0, 2) == 0);
            end else begin
                busy = 1'b0;
            end
            error = pay_err ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            if (!busy) idx++;
            cyc++;
        end
        busy = 1'b0;
        error = 1'b0;
        if (cyc >= 400) begin
            miscompares++;
            $display("FAIL byte_timeout: accepted %0d of %0d bytes", idx, n);
        end
        for (int w = 0; w < ERR_WAIT; w++) begin
            vectors++;
            if (pkt_done !== 1'b0 || d_in !== 8'h00 || pkt_vld !== 1'b0) begin
                miscompares++;
                $display("FAIL wait[%0d]: pkt_done=%b d_in=%h pkt_vld=%b, required 0/00/0", w,
                         pkt_done, d_in, pkt_vld);
            end
            error = err_mask[w];
            errs = errs | err_mask[w];
            busy = 1'($urandom_range(0, 1));
            step();
        end
        error = 1'b0;
        busy = 1'b0;
        if (pkt_m < CNT_MAX) pkt_m++;
        if (errs && err_m < CNT_MAX) err_m++;
        vectors++;
        if (pkt_done !== 1'b1 || pkt_err !== errs || pkt_cnt !== CNT_W'(pkt_m) ||
            err_cnt !== CNT_W'(err_m) || cmd_ready !== (GAP == 0)) begin
            miscompares++;
            $display("FAIL done: done=%b err=%b pkt_cnt=%0d err_cnt=%0d rdy=%b, required 1/%b/%0d/%0d/%b",
                     pkt_done, pkt_err, pkt_cnt, err_cnt, cmd_ready, errs, pkt_m, err_m, GAP == 0);
        end
        step();
        vectors++;
        if (pkt_done !== 1'b0 || pkt_err !== errs) begin
            miscompares++;
            $display("FAIL after_done: pkt_done=%b pkt_err=%b, required 0/%b", pkt_done, pkt_err, errs);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        pkt_m = 0;
        err_m = 0;
        vectors++;
        if (d_in !== 8'h00 || pkt_vld !== 1'b0 || cmd_ready !== 1'b1 || pkt_done !== 1'b0 ||
            pkt_err !== 1'b0 || cmd_err !== 1'b0 || pkt_cnt !== '0 || err_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset: d_in=%h vld=%b rdy=%b done=%b perr=%b cerr=%b cnt=%0d/%0d",
                     d_in, pkt_vld, cmd_ready, pkt_done, pkt_err, cmd_err, pkt_cnt, err_cnt);
        end
    endtask

    task automatic test_basic();
        exp_q = '{8'h0D, 8'hA5, 8'h4A, 8'h95, 8'h77};
        run_packet(2'd1, 6'd3, 8'hA5, 1'b0, 1'b0, -1, 0, 8'h00, 1'b0);
    endtask

    task automatic test_busy_hold();
        exp_q = '{8'h0D, 8'hA5, 8'h4A, 8'h95, 8'h77};
        run_packet(2'd1, 6'd3, 8'hA5, 1'b0, 1'b0, 2, 2, 8'h00, 1'b0);
    endtask

    task automatic test_illegal();
        logic [1:0] addrs[2] = '{2'd1, 2'd3};
        logic [5:0] lens[2]  = '{6'd0, 6'd4};
        for (int k = 0; k < 2; k++) begin
            wait_ready();
            cmd_addr = addrs[k]; cmd_len = lens[k]; cmd_seed = 8'h5A; cmd_valid = 1'b1;
            step();
            cmd_valid = 1'b0;
            vectors++;
            if (cmd_err !== 1'b1 || pkt_vld !== 1'b0 || cmd_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL illegal[%0d]: cmd_err=%b pkt_vld=%b rdy=%b, required 1/0/1", k,
                         cmd_err, pkt_vld, cmd_ready);
            end
            step();
            vectors++;
            if (cmd_err !== 1'b0 || pkt_vld !== 1'b0 || pkt_cnt !== CNT_W'(pkt_m)) begin
                miscompares++;
                $display("FAIL illegal_after[%0d]: cmd_err=%b pkt_vld=%b pkt_cnt=%0d, required 0/0/%0d",
                         k, cmd_err, pkt_vld, pkt_cnt, pkt_m);
            end
        end
    endtask

    task automatic test_error();
        build_exp(2'd2, 4, 8'h3C, 1'b0);
        run_packet(2'd2, 6'd4, 8'h3C, 1'b0, 1'b0, -1, 0, 8'b0000_0010, 1'b1);
        build_exp(2'd0, 5, 8'hC3, 1'b0);
        run_packet(2'd0, 6'd5, 8'hC3, 1'b0, 1'b0, -1, 0, 8'h00, 1'b1);
    endtask

    task automatic test_reset_mid();
        wait_ready();
        cmd_addr = 2'd0; cmd_len = 6'd5; cmd_seed = 8'h11; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        pkt_m = 0;
        err_m = 0;
        vectors++;
        if (pkt_vld !== 1'b0 || d_in !== 8'h00 || cmd_ready !== 1'b1 || pkt_cnt !== '0 ||
            err_cnt !== '0 || pkt_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: vld=%b d_in=%h rdy=%b cnt=%0d/%0d perr=%b", pkt_vld, d_in,
                     cmd_ready, pkt_cnt, err_cnt, pkt_err);
        end
        build_exp(2'd2, 2, 8'h80, 1'b0);
        run_packet(2'd2, 6'd2, 8'h80, 1'b0, 1'b0, -1, 0, 8'h00, 1'b0);
    endtask

    task automatic test_boundary();
        build_exp(2'd1, 1, 8'h00, 1'b0);
        run_packet(2'd1, 6'd1, 8'h00, 1'b0, 1'b1, -1, 0, 8'h00, 1'b0);
        build_exp(2'd2, 63, 8'hFF, 1'b0);
        run_packet(2'd2, 6'd63, 8'hFF, 1'b0, 1'b1, -1, 0, 8'b0000_0100, 1'b0);
    endtask

    task automatic test_random();
        logic [1:0] a;
        logic [5:0] len;
        logic [7:0] seed, em;
        for (int k = 0; k < 20; k++) begin
            a    = 2'($urandom_range(0, 2));
            len  = 6'($urandom_range(1, 12));
            seed = 8'($urandom_range(0, 255));
            em   = ($urandom_range(0, 1) == 1) ? 8'(1 << $urandom_range(0, ERR_WAIT - 1)) : 8'h00;
            build_exp(a, int'(len), seed, 1'b0);
            run_packet(a, len, seed, 1'b0, 1'b1, -1, 0, em, 1'($urandom_range(0, 1)));
        end
    endtask

`ifdef ROUTER_PKT_GEN_CORRUPT_EN
    task automatic test_corrupt();
        exp_q = '{8'h0D, 8'hA5, 8'h4A, 8'h95, 8'h88};
        run_packet(2'd1, 6'd3, 8'hA5, 1'b1, 1'b0, -1, 0, 8'h00, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_busy_hold();
        test_illegal();
        test_error();
        test_reset_mid();
        test_boundary();
        test_random();
`ifdef ROUTER_PKT_GEN_CORRUPT_EN
        test_corrupt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
